// File: rtl/control_unwinder_pkg.sv
// Shared types, encodings and frame field positions for the control-stack unwinder.
// Frame layout widths come from the CALL_STACK_WIDTH / ST_LOG2_DEPTH / INSTR_LOG2_BRAM_DEPTH macros.
`ifndef CALL_STACK_WIDTH
`define CALL_STACK_WIDTH 32
`endif
`ifndef ST_LOG2_DEPTH
`define ST_LOG2_DEPTH 10
`endif
`ifndef INSTR_LOG2_BRAM_DEPTH
`define INSTR_LOG2_BRAM_DEPTH 12
`endif

package control_unwinder_pkg;
  localparam int CS_W = `CALL_STACK_WIDTH;
  localparam int ST_W = `ST_LOG2_DEPTH;
  localparam int IA_W = `INSTR_LOG2_BRAM_DEPTH;

  localparam int TYPE_HI  = 29;
  localparam int TYPE_LO  = 28;
  localparam int RETU_BIT = 27;
  localparam int SP_LO    = IA_W;
  localparam int SP_HI    = ST_W + IA_W - 1;
  localparam int RA_HI    = IA_W - 1;
  localparam int RA_LO    = 0;

  typedef enum logic [1:0] {
    FT_BLOCK = 2'b00,
    FT_CALL  = 2'b01,
    FT_IF    = 2'b10,
    FT_LOOP  = 2'b11
  } frame_type_e;

  localparam logic [1:0] OP_BR     = 2'b00;
  localparam logic [1:0] OP_END    = 2'b01;
  localparam logic [1:0] OP_RETURN = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_UNWIND = 2'b01,
    ST_DONE   = 2'b10,
    ST_ERR    = 2'b11
  } state_e;
endpackage

// File: rtl/control_unwinder_if.sv
// Request, control-stack and result signals of the unwinder, grouped with master/slave views.
interface control_unwinder_if;
  import control_unwinder_pkg::*;

  // A request transfers on a rising edge where req_vld && req_rdy; req_vld may rise at any time
  // and is simply not taken while req_rdy is low (nothing is queued).
  logic            req_vld;
  logic            req_rdy;
  logic [1:0]      req_op;
  logic [7:0]      req_depth;
  logic            cs_shift_vld;
  logic            cs_pop;
  logic            cs_push;
  logic            cs_retu;
  logic [CS_W-1:0] cs_top_data;
  logic            cs_left_one;
  logic            done_vld;
  logic            jump_en;
  logic [IA_W-1:0] jump_addr;
  logic            skip_en;
  logic [ST_W-1:0] sp_tag;
  logic            retu_num;
  logic            halt;
  logic            err;

  modport master (
    output req_vld, req_op, req_depth, cs_top_data, cs_left_one,
    input  req_rdy, cs_shift_vld, cs_pop, cs_push, cs_retu, done_vld,
           jump_en, jump_addr, skip_en, sp_tag, retu_num, halt, err
  );

  modport slave (
    input  req_vld, req_op, req_depth, cs_top_data, cs_left_one,
    output req_rdy, cs_shift_vld, cs_pop, cs_push, cs_retu, done_vld,
           jump_en, jump_addr, skip_en, sp_tag, retu_num, halt, err
  );
endinterface

// File: rtl/control_unwinder_cs_frame_decode.sv
// Splits a control-stack frame into its type, result count, stack-pointer tag and return address.
module cs_frame_decode
  import control_unwinder_pkg::*;
(
  input  logic [CS_W-1:0] frame,
  output frame_type_e     ftype,
  output logic            retu_num,
  output logic [ST_W-1:0] sp_tag,
  output logic [IA_W-1:0] ret_addr
);
  logic unused_bits;

  assign ftype       = frame_type_e'(frame[TYPE_HI:TYPE_LO]);
  assign retu_num    = frame[RETU_BIT];
  assign sp_tag      = frame[SP_HI:SP_LO];
  assign ret_addr    = frame[RA_HI:RA_LO];
  assign unused_bits = ^{frame[CS_W-1:TYPE_HI+1], frame[RETU_BIT-1:SP_HI+1]};
endmodule

// File: rtl/control_unwinder.sv
// Unwinds the control stack for br/end/return and resolves the next PC action.
// Define UNWIND_FAST_RETURN_EN to finish return in one cs_retu cycle instead of frame-by-frame pops.
module control_unwinder
  import control_unwinder_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  control_unwinder_if.slave  u,
  output state_e             dbg_state
);
  state_e          state_q, state_d;
  logic [7:0]      counter_q, counter_d;
  logic [1:0]      op_q, op_d;
  logic            jump_en_q, jump_en_d;
  logic [IA_W-1:0] jump_addr_q, jump_addr_d;
  logic            skip_en_q, skip_en_d;
  logic [ST_W-1:0] sp_tag_q, sp_tag_d;
  logic            retu_num_q, retu_num_d;
  logic            halt_q, halt_d;

  frame_type_e     ftype;
  logic            f_retu;
  logic [ST_W-1:0] f_sp;
  logic [IA_W-1:0] f_ra;
  logic            shift_vld, pop, retu;
  logic            res, res_pop, res_jump, res_skip, res_call;

  cs_frame_decode u_dec (
    .frame    (u.cs_top_data),
    .ftype    (ftype),
    .retu_num (f_retu),
    .sp_tag   (f_sp),
    .ret_addr (f_ra)
  );

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    op_d        = op_q;
    jump_en_d   = jump_en_q;
    jump_addr_d = jump_addr_q;
    skip_en_d   = skip_en_q;
    sp_tag_d    = sp_tag_q;
    retu_num_d  = retu_num_q;
    halt_d      = halt_q;
    shift_vld   = 1'b0;
    pop         = 1'b0;
    retu        = 1'b0;
    res         = 1'b0;
    res_pop     = 1'b0;
    res_jump    = 1'b0;
    res_skip    = 1'b0;
    res_call    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (u.req_vld) begin
          state_d     = ST_UNWIND;
          op_d        = u.req_op;
          counter_d   = (u.req_op == OP_BR) ? u.req_depth : 8'd0;
          jump_en_d   = 1'b0;
          jump_addr_d = '0;
          skip_en_d   = 1'b0;
          sp_tag_d    = '0;
          retu_num_d  = 1'b0;
          halt_d      = 1'b0;
        end
      end
      ST_UNWIND: begin
        case (op_q)
          OP_BR, OP_END: begin
            if (counter_q != 8'd0) begin
              // Intermediate frames may never cross a function boundary.
              if (ftype == FT_CALL) begin
                state_d = ST_ERR;
              end else begin
                shift_vld = 1'b1;
                pop       = 1'b1;
                counter_d = counter_q - 8'd1;
              end
            end else begin
              res      = 1'b1;
              res_call = (ftype == FT_CALL);
              res_pop  = !((op_q == OP_BR) && (ftype == FT_LOOP));
              res_jump = res_call || ((op_q == OP_BR) && (ftype == FT_LOOP));
              res_skip = (op_q == OP_BR) && ((ftype == FT_BLOCK) || (ftype == FT_IF));
            end
          end
          OP_RETURN: begin
`ifdef UNWIND_FAST_RETURN_EN
            shift_vld = 1'b1;
            retu      = 1'b1;
            res       = 1'b1;
            res_jump  = 1'b1;
            res_call  = 1'b1;
`else
            if (ftype == FT_CALL) begin
              res      = 1'b1;
              res_pop  = 1'b1;
              res_jump = 1'b1;
              res_call = 1'b1;
            end else begin
              shift_vld = 1'b1;
              pop       = 1'b1;
            end
`endif
          end
          default: state_d = ST_ERR;
        endcase
        if (res) begin
          state_d     = ST_DONE;
          sp_tag_d    = f_sp;
          retu_num_d  = f_retu;
          jump_addr_d = f_ra;
          skip_en_d   = res_skip;
          // Removing the bottom call frame ends the program instead of jumping.
          halt_d      = res_call && u.cs_left_one;
          jump_en_d   = res_jump && !(res_call && u.cs_left_one);
          if (res_pop) begin
            shift_vld = 1'b1;
            pop       = 1'b1;
          end
        end
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      counter_q   <= '0;
      op_q        <= '0;
      jump_en_q   <= 1'b0;
      jump_addr_q <= '0;
      skip_en_q   <= 1'b0;
      sp_tag_q    <= '0;
      retu_num_q  <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      op_q        <= op_d;
      jump_en_q   <= jump_en_d;
      jump_addr_q <= jump_addr_d;
      skip_en_q   <= skip_en_d;
      sp_tag_q    <= sp_tag_d;
      retu_num_q  <= retu_num_d;
      halt_q      <= halt_d;
    end
  end

  assign u.req_rdy      = (state_q == ST_IDLE);
  assign u.cs_shift_vld = shift_vld;
  assign u.cs_pop       = pop;
  assign u.cs_retu      = retu;
  assign u.cs_push      = 1'b0;
  assign u.done_vld     = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign u.err          = (state_q == ST_ERR);
  assign u.jump_en      = jump_en_q;
  assign u.jump_addr    = jump_addr_q;
  assign u.skip_en      = skip_en_q;
  assign u.sp_tag       = sp_tag_q;
  assign u.retu_num     = retu_num_q;
  assign u.halt         = halt_q;
  assign dbg_state      = state_q;
endmodule
